// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: word and register-index widths used by the
// register bank, its bus interface and the pending-writeback counters.
package cpu_pkg;

  localparam int NUM_ARCH_REGS  = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_ARCH_REGS);
  localparam int PEND_DEFAULT_W = 2;

  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  // True when a port is active and addresses the given register.
  function automatic logic addr_hit(input logic en, input reg_addr_t a, input reg_addr_t b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/cpu_reg_bank_if.sv
// Bus between the pipeline (writeback, decode, issue) and the register bank.
// The pipeline side is the master; the bank is the slave.
interface cpu_reg_bank_if;
  import cpu_pkg::*;

  // writeback commit port
  logic      write_enable;
  reg_addr_t write_reg;
  word_t     write_data;

  // decode read ports
  reg_addr_t read_reg_a;
  reg_addr_t read_reg_b;
  word_t     read_data_a;
  word_t     read_data_b;

  // issue-side scoreboard control
  logic      mark_valid;
  reg_addr_t mark_reg;
  logic      flush;

  // hazard and health status
  logic      busy_a;
  logic      busy_b;
  logic      sb_error;

  modport master (
    output write_enable, write_reg, write_data,
    output read_reg_a, read_reg_b,
    output mark_valid, mark_reg, flush,
    input  read_data_a, read_data_b,
    input  busy_a, busy_b, sb_error
  );

  modport slave (
    input  write_enable, write_reg, write_data,
    input  read_reg_a, read_reg_b,
    input  mark_valid, mark_reg, flush,
    output read_data_a, read_data_b,
    output busy_a, busy_b, sb_error
  );

endinterface

// File: rtl/cpu_pend_counter.sv
// Saturating up/down counter of outstanding writebacks for one register.
// err pulses in the cycle an increment hits the ceiling or a decrement
// hits the floor; the count holds in both cases. clear wins over all.
module cpu_pend_counter #(
  parameter int PEND_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  clear,
  output logic [PEND_WIDTH-1:0] count,
  output logic                  err
);

  localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] CNT_ONE = PEND_WIDTH'(1);

  logic [PEND_WIDTH-1:0] count_q;
  logic [PEND_WIDTH-1:0] count_d;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [PEND_WIDTH-1:0] sat_inc(input logic [PEND_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Decrement that sticks at zero instead of wrapping.
  function automatic logic [PEND_WIDTH-1:0] sat_dec(input logic [PEND_WIDTH-1:0] c);
    return (c == '0) ? c : c - CNT_ONE;
  endfunction

  // Next count and saturation error; simultaneous inc/dec cancel out.
  always_comb begin
    count_d = count_q;
    err     = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (inc && !dec) begin
      count_d = sat_inc(count_q);
      err     = (count_q == CNT_MAX);
    end else if (dec && !inc) begin
      count_d = sat_dec(count_q);
      err     = (count_q == '0);
    end
  end

  // Counter state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_reg_bank.sv
// Architectural register file with write-first bypass on both read ports and
// a per-register scoreboard of issued-but-not-retired writes. busy_x tells
// decode that a source still owes a writeback which bypass cannot supply.
module cpu_reg_bank
  import cpu_pkg::*;
#(
  parameter int NUM_REGS   = NUM_ARCH_REGS,
  parameter int PEND_WIDTH = PEND_DEFAULT_W
) (
  input logic           clock,
  input logic           reset,
  cpu_reg_bank_if.slave bus
);

  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  word_t                 regs    [NUM_REGS];
  logic [PEND_WIDTH-1:0] pend    [NUM_REGS];
  logic [NUM_REGS-1:0]   cnt_err;
  logic                  sb_error_q;

  logic                  hit_a;
  logic                  hit_b;
  logic [PEND_WIDTH-1:0] pend_a;
  logic [PEND_WIDTH-1:0] pend_b;

  // Register storage: cleared on reset, commit on write_enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.write_enable) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  // One pending counter per register; flush discards marks and retires alike.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    cpu_pend_counter #(
      .PEND_WIDTH (PEND_WIDTH)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (addr_hit(bus.mark_valid,   bus.mark_reg,  reg_addr_t'(g))),
      .dec   (addr_hit(bus.write_enable, bus.write_reg, reg_addr_t'(g))),
      .clear (bus.flush),
      .count (pend[g]),
      .err   (cnt_err[g])
    );
  end

  // Sticky scoreboard error: any counter overflow/underflow until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         sb_error_q <= 1'b0;
    else if (|cnt_err) sb_error_q <= 1'b1;
  end

  // Read ports with write-first bypass and retire-aware busy.
  always_comb begin
    hit_a           = addr_hit(bus.write_enable, bus.write_reg, bus.read_reg_a);
    hit_b           = addr_hit(bus.write_enable, bus.write_reg, bus.read_reg_b);
    pend_a          = pend[bus.read_reg_a];
    pend_b          = pend[bus.read_reg_b];
    bus.read_data_a = hit_a ? bus.write_data : regs[bus.read_reg_a];
    bus.read_data_b = hit_b ? bus.write_data : regs[bus.read_reg_b];
    // A lone outstanding write that retires this cycle is covered by bypass.
    bus.busy_a      = (pend_a != '0) && !((pend_a == PEND_ONE) && hit_a);
    bus.busy_b      = (pend_b != '0) && !((pend_b == PEND_ONE) && hit_b);
  end

  assign bus.sb_error = sb_error_q;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Directed bench for cpu_reg_bank: bypass reads, scoreboard busy tracking,
// saturation errors, flush and asynchronous reset.
module tb_cpu_reg_bank;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  cpu_reg_bank_if bus ();

  cpu_reg_bank dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks land 1ns later.
  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic fl);
    @(negedge clock);
    bus.write_enable = we;
    bus.write_reg    = wr;
    bus.write_data   = wd;
    bus.mark_valid   = mv;
    bus.mark_reg     = mr;
    bus.flush        = fl;
    #1;
  endtask

  initial begin
    bus.write_enable = 1'b0;
    bus.write_reg    = '0;
    bus.write_data   = '0;
    bus.read_reg_a   = 5'd3;
    bus.read_reg_b   = 5'd31;
    bus.mark_valid   = 1'b0;
    bus.mark_reg     = '0;
    bus.flush        = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_rda", bus.read_data_a, 32'h0);
    chk("rst_rdb", bus.read_data_b, 32'h0);
    chk("rst_busy_a", {31'b0, bus.busy_a}, 32'h0);
    chk("rst_busy_b", {31'b0, bus.busy_b}, 32'h0);
    chk("rst_err", {31'b0, bus.sb_error}, 32'h0);

    // Bypass write to r5 (marked first so the retire is legitimate)
    bus.read_reg_a = 5'd5;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    chk("byp_r5", bus.read_data_a, 32'hDEADBEEF);
    chk("byp_r5_busy", {31'b0, bus.busy_a}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("store_r5", bus.read_data_a, 32'hDEADBEEF);
    chk("r5_err", {31'b0, bus.sb_error}, 32'h0);

    // Mark r7: busy one cycle later, cleared by retiring write in same cycle
    bus.read_reg_a = 5'd7;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    chk("mark7_busy0", {31'b0, bus.busy_a}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("mark7_busy1", {31'b0, bus.busy_a}, 32'h1);
    drive(1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 1'b0);
    chk("ret7_busy", {31'b0, bus.busy_a}, 32'h0);
    chk("ret7_rda", bus.read_data_a, 32'h12);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("post7_busy", {31'b0, bus.busy_a}, 32'h0);
    chk("post7_rda", bus.read_data_a, 32'h12);

    // r9: mark+write same cycle keeps pend at 1; then flush with write
    bus.read_reg_a = 5'd9;
    bus.read_reg_b = 5'd10;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    drive(1'b1, 5'd9, 32'h33, 1'b1, 5'd9, 1'b0);
    chk("mw9_rda", bus.read_data_a, 32'h33);
    chk("mw9_busy_byp", {31'b0, bus.busy_a}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("mw9_busy", {31'b0, bus.busy_a}, 32'h1);
    chk("mw9_store", bus.read_data_a, 32'h33);
    drive(1'b1, 5'd9, 32'h55, 1'b1, 5'd10, 1'b1);
    chk("fl_rda", bus.read_data_a, 32'h55);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("fl_busy9", {31'b0, bus.busy_a}, 32'h0);
    chk("fl_busy10", {31'b0, bus.busy_b}, 32'h0);
    chk("fl_r9", bus.read_data_a, 32'h55);
    chk("fl_err", {31'b0, bus.sb_error}, 32'h0);

    // Underflow on r4 (also mark r9 so busy is live before reset)
    bus.read_reg_a = 5'd4;
    bus.read_reg_b = 5'd9;
    drive(1'b1, 5'd4, 32'hA5A5, 1'b1, 5'd9, 1'b0);
    chk("uf_rda", bus.read_data_a, 32'hA5A5);
    chk("uf_err_pre", {31'b0, bus.sb_error}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("uf_store", bus.read_data_a, 32'hA5A5);
    chk("uf_err", {31'b0, bus.sb_error}, 32'h1);
    chk("pre_rst_busy_b", {31'b0, bus.busy_b}, 32'h1);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("arst_rda", bus.read_data_a, 32'h0);
    chk("arst_rdb", bus.read_data_b, 32'h0);
    chk("arst_busy_b", {31'b0, bus.busy_b}, 32'h0);
    chk("arst_err", {31'b0, bus.sb_error}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Overflow on r2: three marks fill, fourth saturates and flags
    bus.read_reg_a = 5'd2;
    repeat (4) drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("of_err", {31'b0, bus.sb_error}, 32'h1);
    chk("of_busy", {31'b0, bus.busy_a}, 32'h1);
    drive(1'b1, 5'd2, 32'h101, 1'b0, 5'd0, 1'b0);
    chk("of_w1_busy", {31'b0, bus.busy_a}, 32'h1);
    chk("of_w1_rda", bus.read_data_a, 32'h101);
    drive(1'b1, 5'd2, 32'h202, 1'b0, 5'd0, 1'b0);
    chk("of_w2_busy", {31'b0, bus.busy_a}, 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("of_w2_hold", {31'b0, bus.busy_a}, 32'h1);
    chk("of_w2_store", bus.read_data_a, 32'h202);
    drive(1'b1, 5'd2, 32'h303, 1'b0, 5'd0, 1'b0);
    chk("of_w3_busy", {31'b0, bus.busy_a}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("of_w3_clear", {31'b0, bus.busy_a}, 32'h0);
    chk("of_w3_store", bus.read_data_a, 32'h303);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_reg_bank.md
# cpu_reg_bank

Architectural register bank with an in-flight write scoreboard. It is the write-port endpoint driven by the writeback stage (write_enable/write_reg/write_data). It also serves two combinational read ports to decode, with same-cycle write bypass. Per register, it tracks how many issued instructions still owe a writeback, so decode can stall on true RAW hazards that forwarding cannot cover.

## Interface
- NUM_REGS, 32, number of architectural registers (all writable, no hardwired zero)
- DATA_WIDTH, 32, register width
- REG_ADDR_WIDTH, $clog2(NUM_REGS), register index width
- PEND_WIDTH, 2, width of each per-register pending counter (max 2^PEND_WIDTH-1 in flight)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- write_enable  in  1  writeback commits a result this cycle
- write_reg  in  REG_ADDR_WIDTH  destination of the commit
- write_data  in  DATA_WIDTH  value committed
- read_reg_a / read_reg_b  in  REG_ADDR_WIDTH  decode source indices
- read_data_a / read_data_b  out  DATA_WIDTH  source values
- mark_valid  in  1  decode issues an instruction that will write mark_reg
- mark_reg  in  REG_ADDR_WIDTH  destination being issued
- flush  in  1  pipeline flush: discard all pending marks
- busy_a / busy_b  out  1  source still has an outstanding writeback
- sb_error  out  1  sticky: counter overflow or underflow seen

## Operation
- Storage: NUM_REGS x DATA_WIDTH flops. On an edge with write_enable, regs[write_reg] <= write_data.
- Read with write-first bypass: read_data_x = write_data if write_enable && write_reg == read_reg_x, else regs[read_reg_x].
- Scoreboard: each register has a counter pend[r].
  - Increment when mark_valid && mark_reg == r.
  - Decrement when write_enable && write_reg == r.
  - Both in the same cycle: unchanged.
- Overflow: an increment at max holds the counter at max and sets sb_error.
- Underflow: a decrement at 0 holds the counter at 0, sets sb_error, and the data write still occurs.
- flush: every pend[r] <= 0, and a mark in the same cycle is ignored. A write in the same cycle still updates regs. No underflow error is raised in the flush cycle.
- busy_x = (pend[read_reg_x] != 0), with bypass awareness: busy_x is 0 when pend == 1 and the same-cycle write retires that register.
  - A same-cycle mark does not raise busy until the next cycle.
- sb_error stays set until reset.

## Timing
- Reset values: all regs 0, all pend 0, sb_error 0. As a result, read_data_a/b = 0 and busy_a/b = 0 while no write is presented.
- Write latency: 0 cycles via bypass. The stored value is visible from the cycle after the commit edge.
- Mark-to-busy latency: 1 cycle. Retire-to-clear latency: 0 cycles (bypass-aware busy).
- Reads, bypass and busy are purely combinational from current inputs and state. There is no read enable or handshake.
- Reset asserted mid-operation clears everything immediately (asynchronous). Inputs are ignored until the first edge after deassertion.

## Structure
- Shared package cpu_pkg holds DATA_WIDTH, REG_ADDR_WIDTH, typedef word_t, and typedef reg_addr_t.
- The per-register up/down saturating counter is a natural sub-module: cpu_pend_counter.
  - Ports: inc, dec, clear, count, err.
  - Instantiated NUM_REGS times.
  - The block ORs the err outputs into the sticky sb_error.

## Test plan
- Reset, then read_reg_a=3, read_reg_b=31 → read_data 0/0, busy 0/0, sb_error 0.
- write_enable, write_reg=5, write_data=0xDEADBEEF, read_reg_a=5, same cycle → read_data_a=0xDEADBEEF. With write_enable dropped next cycle, read_data_a is still 0xDEADBEEF.
- mark r7 → busy_a (read_reg_a=7) 0 in the mark cycle, 1 the next. Write r7=0x12 → busy_a 0 and read_data_a=0x12 in the write cycle.
- mark r2 three times → pend=3. A fourth mark sets sb_error=1 and pend stays 3. Two writes to r2 leave busy set; the third clears it.
- mark r9 and write r9 in the same cycle with pend[r9]=1 → pend stays 1, busy stays 1. Then flush plus write r9=0x55 → pend 0, regs[9]=0x55, no error.
- write r4 with pend=0 → regs[4] updated and sb_error=1. Reset asserted asynchronously mid-cycle → all outputs return to 0 immediately.
